// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
// Owns the single register-file write port and arbitrates EX, load-return and
// mult/div results onto it. Also keeps a busy scoreboard for long-latency
// destinations and raises an issue stall on read-after-write and
// write-after-write hazards.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // EX result: single-cycle, cannot be back-pressured
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  // load return
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  // mult/div return
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  // issue-stage hazard interface
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] iss_rs,
  input  logic [ADDR_W-1:0] iss_rt,
  output logic              stall,
  // register file write port
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  // Counter must be able to hold STARVE_MAX; keep at least one bit.
  localparam int unsigned CntW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    SrcNone,
    SrcEx,
    SrcLd,
    SrcMd
  } src_e;

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    starve_q, starve_d;
  src_e               src;
  logic               starve_hit;
  logic [ADDR_W-1:0]  wr_rd;
  logic [DATA_W-1:0]  wr_data;
  logic               issue_set;

  // Write-port arbitration: EX first, then mult/div if it has starved or load is idle.
  always_comb begin
    starve_hit = (starve_q == CntW'(STARVE_MAX));
    src        = SrcNone;
    if (reset) begin
      src = SrcNone;
    end else if (ex_valid) begin
      src = SrcEx;
    end else if (md_valid && (starve_hit || !ld_valid)) begin
      src = SrcMd;
    end else if (ld_valid) begin
      src = SrcLd;
    end
  end

  // Steer the winning source onto the register-file write port.
  always_comb begin
    wr_rd   = '0;
    wr_data = '0;
    unique case (src)
      SrcEx: begin
        wr_rd   = ex_rd;
        wr_data = ex_data;
      end
      SrcLd: begin
        wr_rd   = ld_rd;
        wr_data = ld_data;
      end
      SrcMd: begin
        wr_rd   = md_rd;
        wr_data = md_data;
      end
      SrcNone: begin
        wr_rd   = '0;
        wr_data = '0;
      end
    endcase
  end

  // Handshake and write-enable outputs; a $0 grant still completes the handshake.
  always_comb begin
    ld_ready  = (src == SrcLd);
    md_ready  = (src == SrcMd);
    RegWrite  = (src != SrcNone) && (wr_rd != '0);
    WriteReg  = wr_rd;
    WriteData = wr_data;
  end

  // Hazard stall: no bypass, so a clearing write still stalls in its own cycle.
  always_comb begin
    stall     = !reset && iss_valid &&
                (busy_q[iss_rs] || busy_q[iss_rt] || busy_q[iss_rd]);
    issue_set = iss_valid && !stall && (iss_rd != '0);
  end

  // Scoreboard next state: clear on ld/md retire, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (ld_ready || md_ready) begin
      busy_d[wr_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter next state: count waiting md cycles, saturate, clear otherwise.
  always_comb begin
    starve_d = '0;
    if (md_valid && !md_ready) begin
      starve_d = starve_hit ? starve_q : starve_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  // Sources must hold a pending result stable until it is accepted.
  ld_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (ld_valid && !ld_ready) |=> (ld_valid && $stable(ld_rd) && $stable(ld_data)));

  md_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (md_valid && !md_ready) |=> (md_valid && $stable(md_rd) && $stable(md_data)));

  // EX has absolute priority, so a grant to ld/md never coexists with ex_valid.
  ex_exclusive: assert property (@(posedge clk) disable iff (reset)
    ex_valid |-> (!ld_ready && !md_ready));

  // At most one of the queued sources is accepted per cycle.
  one_grant: assert property (@(posedge clk) !(ld_ready && md_ready));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a table of single-cycle arbitration vectors,
// hand-written multi-cycle sequences, and a randomized run, all compared
// against a rule-level reference model of priority, starvation and busy bits.
module tb_regfile_wb_scheduler;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ld_valid, md_valid, iss_valid;
  logic [AW-1:0] ex_rd, ld_rd, md_rd, iss_rd, iss_rs, iss_rt;
  logic [DW-1:0] ex_data, ld_data, md_data;
  logic          ld_ready, md_ready, stall, RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex_rd    (ex_rd),
    .ex_data  (ex_data),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .md_valid (md_valid),
    .md_rd    (md_rd),
    .md_data  (md_data),
    .md_ready (md_ready),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_rs   (iss_rs),
    .iss_rt   (iss_rt),
    .stall    (stall),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData)
  );

  // Reference model state: which registers await a long-latency result, and
  // how many consecutive cycles the pending mult/div result has been passed over.
  bit            m_busy[32];
  int            m_starve;
  // Expected outputs for the current cycle (0 none, 1 ex, 2 ld, 3 md).
  int            e_src;
  logic [AW-1:0] e_rd;
  logic [DW-1:0] e_data;
  bit            e_rw, e_stall;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit            exv;
    logic [AW-1:0] exrd;
    logic [DW-1:0] exd;
    bit            ldv;
    logic [AW-1:0] ldrd;
    logic [DW-1:0] ldd;
    bit            mdv;
    logic [AW-1:0] mdrd;
    logic [DW-1:0] mdd;
    bit            rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    bit            lr;
    bit            mr;
  } vec_t;

  vec_t tbl[8];

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_valid  = 1'b0; ex_rd  = '0; ex_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data = '0;
    md_valid  = 1'b0; md_rd  = '0; md_data = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_rs  = '0; iss_rt = '0;
  endtask

  // Predict this cycle's outputs from the rules, then compare mid-cycle.
  task automatic eval();
    e_src = 0;
    if (!reset) begin
      if (ex_valid) e_src = 1;
      else if (md_valid && (m_starve == SMAX || !ld_valid)) e_src = 3;
      else if (ld_valid) e_src = 2;
    end
    e_rd   = '0;
    e_data = '0;
    if (e_src == 1) begin e_rd = ex_rd; e_data = ex_data; end
    if (e_src == 2) begin e_rd = ld_rd; e_data = ld_data; end
    if (e_src == 3) begin e_rd = md_rd; e_data = md_data; end
    e_rw    = (e_src != 0) && (e_rd != 0);
    e_stall = !reset && iss_valid && (m_busy[iss_rs] || m_busy[iss_rt] || m_busy[iss_rd]);
    @(negedge clk);
    n_vec++;
    cmp("RegWrite", DW'(RegWrite), DW'(e_rw));
    cmp("ld_ready", DW'(ld_ready), DW'(e_src == 2));
    cmp("md_ready", DW'(md_ready), DW'(e_src == 3));
    cmp("stall", DW'(stall), DW'(e_stall));
    if (e_rw) begin
      cmp("WriteReg", DW'(WriteReg), DW'(e_rd));
      cmp("WriteData", WriteData, e_data);
    end
  endtask

  // Advance the model across the clock edge using the inputs of the cycle just checked.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_starve = 0;
    end else begin
      if (e_src == 2 || e_src == 3) m_busy[e_rd] = 1'b0;
      if (iss_valid && !e_stall && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (md_valid && e_src != 3) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    eval();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_starve = 0;
    reset    = 1'b1;
    clear_inputs();

    //               exv exrd exd            ldv ldrd ldd       mdv mdrd mdd      rw wr wd            lr mr
    tbl[0] = '{1, 3,  32'h0000_00A1, 1, 4, 32'h0000_00B2, 1, 5, 32'h0000_00C3, 1, 3,  32'h0000_00A1, 0, 0};
    tbl[1] = '{0, 0,  32'h0,         1, 4, 32'h0000_00B2, 1, 5, 32'h0000_00C3, 1, 4,  32'h0000_00B2, 1, 0};
    tbl[2] = '{0, 0,  32'h0,         0, 0, 32'h0,         1, 5, 32'h0000_00C3, 1, 5,  32'h0000_00C3, 0, 1};
    tbl[3] = '{0, 0,  32'h0,         1, 0, 32'h0000_00B2, 0, 0, 32'h0,         0, 0,  32'h0,         1, 0};
    tbl[4] = '{1, 0,  32'h0000_00A1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  32'h0,         0, 0};
    tbl[5] = '{0, 0,  32'h0,         0, 0, 32'h0,         1, 0, 32'h0000_00C3, 0, 0,  32'h0,         0, 1};
    tbl[6] = '{1, 31, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 7, 32'h1234_5678, 1, 31, 32'hDEAD_BEEF, 0, 0};
    tbl[7] = '{0, 0,  32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  32'h0,         0, 0};

    @(posedge clk);
    #1;

    // Table: each vector from a freshly reset state.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ex_valid = tbl[i].exv; ex_rd = tbl[i].exrd; ex_data = tbl[i].exd;
      ld_valid = tbl[i].ldv; ld_rd = tbl[i].ldrd; ld_data = tbl[i].ldd;
      md_valid = tbl[i].mdv; md_rd = tbl[i].mdrd; md_data = tbl[i].mdd;
      eval();
      cmp($sformatf("tbl%0d.RegWrite", i), DW'(RegWrite), DW'(tbl[i].rw));
      cmp($sformatf("tbl%0d.ld_ready", i), DW'(ld_ready), DW'(tbl[i].lr));
      cmp($sformatf("tbl%0d.md_ready", i), DW'(md_ready), DW'(tbl[i].mr));
      if (tbl[i].rw) begin
        cmp($sformatf("tbl%0d.WriteReg", i), DW'(WriteReg), DW'(tbl[i].wr));
        cmp($sformatf("tbl%0d.WriteData", i), WriteData, tbl[i].wd);
      end
      tick();
    end

    // Reset clears a busy register.
    do_reset();
    iss_valid = 1'b1; iss_rd = 5;
    eval(); tick();
    iss_valid = 1'b1; iss_rd = 0; iss_rs = 5;
    eval();
    cmp("busy5_before_reset", DW'(stall), DW'(1));
    clear_inputs();
    reset = 1'b1;
    eval(); tick();
    reset = 1'b0;
    iss_valid = 1'b1; iss_rs = 5;
    eval();
    cmp("stall_after_reset", DW'(stall), DW'(0));
    cmp("regwrite_after_reset", DW'(RegWrite), DW'(0));
    tick();

    // Starvation: ld wins four cycles, md the fifth, then ld resumes.
    do_reset();
    ld_valid = 1'b1; ld_rd = 4; ld_data = 32'h4444_0000;
    md_valid = 1'b1; md_rd = 5; md_data = 32'h5555_0000;
    for (int c = 1; c <= 4; c++) begin
      eval();
      cmp($sformatf("starve_c%0d_ld", c), DW'(ld_ready), DW'(1));
      cmp($sformatf("starve_c%0d_md", c), DW'(md_ready), DW'(0));
      tick();
    end
    eval();
    cmp("starve_c5_md", DW'(md_ready), DW'(1));
    cmp("starve_c5_wr", DW'(WriteReg), DW'(5));
    tick();
    md_data = 32'h5555_0001;
    eval();
    cmp("starve_c6_ld", DW'(ld_ready), DW'(1));
    tick();

    // Scoreboard: issue to r8, stall on r8, load retires r8, stall drops a cycle later.
    do_reset();
    iss_valid = 1'b1; iss_rd = 8;
    eval(); tick();
    iss_rd = 10; iss_rs = 8;
    eval();
    cmp("sb_stall_set", DW'(stall), DW'(1));
    tick();
    ld_valid = 1'b1; ld_rd = 8; ld_data = 32'h0000_0888;
    eval();
    cmp("sb_stall_clear_cycle", DW'(stall), DW'(1));
    cmp("sb_ld_write", DW'(WriteReg), DW'(8));
    tick();
    ld_valid = 1'b0;
    eval();
    cmp("sb_stall_dropped", DW'(stall), DW'(0));
    tick();

    // $0: load to r0 handshakes without writing; issue to r0 marks nothing.
    do_reset();
    ld_valid = 1'b1; ld_rd = 0; ld_data = 32'hFFFF_FFFF;
    eval();
    cmp("r0_ld_ready", DW'(ld_ready), DW'(1));
    cmp("r0_regwrite", DW'(RegWrite), DW'(0));
    tick();
    ld_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 0;
    eval(); tick();
    eval();
    cmp("r0_no_stall", DW'(stall), DW'(0));
    tick();

    // Same-cycle set and clear on r9: set wins.
    do_reset();
    md_valid = 1'b1; md_rd = 9; md_data = 32'h0000_0999;
    iss_valid = 1'b1; iss_rd = 9;
    eval();
    cmp("setclr_md_ready", DW'(md_ready), DW'(1));
    tick();
    md_valid = 1'b0;
    iss_rd = 0; iss_rs = 9;
    eval();
    cmp("setclr_busy9", DW'(stall), DW'(1));
    tick();

    // Randomized traffic with handshake-respecting sources.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        ld_valid = 1'b0;
        md_valid = 1'b0;
      end else begin
        if (!ld_valid && $urandom_range(0, 1) == 1) begin
          ld_valid = 1'b1; ld_rd = AW'($urandom_range(0, 7)); ld_data = $urandom;
        end
        if (!md_valid && $urandom_range(0, 2) == 0) begin
          md_valid = 1'b1; md_rd = AW'($urandom_range(0, 7)); md_data = $urandom;
        end
      end
      ex_valid  = ($urandom_range(0, 3) == 0);
      ex_rd     = AW'($urandom_range(0, 31));
      ex_data   = $urandom;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom_range(0, 7));
      iss_rs    = AW'($urandom_range(0, 7));
      iss_rt    = AW'($urandom_range(0, 7));
      eval();
      tick();
      if (e_src == 2) ld_valid = 1'b0;
      if (e_src == 3) md_valid = 1'b0;
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates three writeback sources: the single-cycle ALU/EX result, load return from memory, and the multi-cycle mult/div unit.
- Keeps a per-register busy scoreboard for long-latency destinations and gives the issue stage a hazard stall.
- Sits between the execute/memory/muldiv units and the register file's RegWrite/WriteReg/WriteData inputs.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- STARVE_MAX, 4, cycles mult/div may wait before it overrides load priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX result wants write this cycle; cannot be back-pressured
- ex_rd  in  ADDR_W  EX destination
- ex_data  in  DATA_W  EX result
- ld_valid  in  1  load result available
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load result accepted this cycle
- md_valid  in  1  mult/div result available
- md_rd  in  ADDR_W  mult/div destination
- md_data  in  DATA_W  mult/div result
- md_ready  out  1  mult/div result accepted this cycle
- iss_valid  in  1  issuing a long-latency op (load or mult/div)
- iss_rd  in  ADDR_W  its destination, marked busy
- iss_rs, iss_rt  in  ADDR_W  sources of the instruction being issued
- stall  out  1  issue must hold: a source or iss_rd is busy
- RegWrite  out  1  register file write enable
- WriteReg  out  ADDR_W  register file write index
- WriteData  out  DATA_W  register file write data

Behaviour:
- Reset: busy[] all 0, starve counter 0. While reset is high, RegWrite, ld_ready and md_ready are forced to 0 and stall is 0.
- Write-port arbitration is combinational; the grant, RegWrite, WriteReg and WriteData appear in the same cycle. The register file commits on the next posedge.
- Default priority: ex > ld > md.
  - If ex_valid, EX always wins, and ld_ready = md_ready = 0.
  - Starvation override: when the starve counter equals STARVE_MAX and ex_valid = 0, md is granted over ld.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle md_valid = 1 and md is not granted.
  - Clears on an md grant or when md_valid = 0.
- Handshake: ld/md hold valid, rd and data stable until ready. A result transfers on a cycle with valid & ready.
- $0 handling:
  - A grant whose rd = 0 still pulses ready but drives RegWrite = 0.
  - busy[0] is never set, and register 0 never stalls.
- Scoreboard set: on posedge, if iss_valid & !stall & iss_rd != 0, then busy[iss_rd] <= 1.
- Scoreboard clear: on posedge, a granted ld or md write clears busy[rd].
  - If the set and the clear hit the same index in the same cycle, the set wins.
- stall = iss_valid & (busy[iss_rs] | busy[iss_rt] | busy[iss_rd]). There is no bypass, so stall is still asserted in the clear cycle and drops the following cycle.
- EX writes never touch busy[].
- iss_valid while stall = 1 has no effect on state.
- Reset mid-operation: busy[] and counter clear, and pending ld/md handshakes are dropped without a write. Sources must re-present after reset.

Test Plan:
- Reset with busy set: reset for 1 cycle -> busy all 0, RegWrite = 0, stall = 0 on the next cycle with iss_rs = 5 while busy[5] was previously 1.
- Three-way contention: ex_valid = ld_valid = md_valid = 1 with rd 3, 4, 5 -> RegWrite = 1, WriteReg = 3, WriteData = ex_data, ld_ready = md_ready = 0. Drop ex -> WriteReg = 4, ld_ready = 1.
- Starvation: md_valid held with ld_valid continuously and ex idle -> ld granted 4 cycles, md granted on cycle 5 (md_ready = 1, WriteReg = md_rd), counter back to 0.
- Scoreboard: issue with iss_rd = 8 -> next cycle, iss_rs = 8 gives stall = 1. Load writes reg 8 -> stall still 1 that cycle, 0 on the next.
- $0: ld_valid with ld_rd = 0 -> ld_ready = 1, RegWrite = 0. iss_rd = 0 -> busy unchanged, stall = 0.
- Same-cycle set and clear: md commits reg 9 while a new issue has iss_rd = 9 -> busy[9] = 1 afterwards.
